config_loader: RTL and testbench



---
 rtl/config_loader.sv | 157 +++++++++++++++
 tb/tb_config_loader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// config_loader: turns an (address, data) word stream into timed writes on the tile config bus.
// Define CONFIG_LOADER_CHECKSUM_EN to verify the terminator data word against an XOR checksum.

module config_loader #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] END_ADDR    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] write_count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMR_W  = $clog2(HOLD_CYCLES + GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WRITE, S_GAP, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] addr_reg, addr_nxt;
  logic [WORD_W-1:0] data_reg, data_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic              ready_nxt, busy_nxt, done_nxt, error_nxt;
  logic [WORD_W-1:0] bus_addr_nxt, bus_data_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              fire;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum, checksum_nxt;
`endif

  assign fire = in_valid && in_ready;

  // Next state plus next value of every registered output
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_reg;
    data_nxt  = data_reg;
    timer_nxt = timer;
    busy_nxt  = busy;
    done_nxt  = done;
    error_nxt = error;
    count_nxt = write_count;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    checksum_nxt = checksum;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_ADDR;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
          count_nxt = '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          checksum_nxt = '0;
`endif
        end
      end
      S_ADDR: begin
        if (fire) begin
          addr_nxt  = in_data;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (fire) begin
          if (addr_reg == END_ADDR) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            error_nxt = (in_data != checksum);
`endif
          end else begin
            data_nxt  = in_data;
            timer_nxt = TMR_W'(HOLD_CYCLES - 1);
            state_nxt = S_WRITE;
            if (write_count != '1) count_nxt = write_count + CNT_W'(1);
`ifdef CONFIG_LOADER_CHECKSUM_EN
            checksum_nxt = checksum ^ addr_reg ^ in_data;
`endif
          end
        end
      end
      S_WRITE: begin
        if (timer == '0) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = S_GAP;
            timer_nxt = TMR_W'(GAP_CYCLES - 1);
          end else begin
            state_nxt = S_ADDR;
          end
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (timer == '0) state_nxt = S_ADDR;
        else             timer_nxt = timer - TMR_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase

    // Bus carries a write only while in WRITE so tiles never see a stale target
    ready_nxt    = (state_nxt == S_ADDR) || (state_nxt == S_DATA);
    bus_addr_nxt = (state_nxt == S_WRITE) ? addr_nxt : IDLE_ADDR;
    bus_data_nxt = (state_nxt == S_WRITE) ? data_nxt : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr_reg    <= '0;
      data_reg    <= '0;
      timer       <= '0;
      in_ready    <= 1'b0;
      config_addr <= IDLE_ADDR;
      config_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      write_count <= '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      state       <= state_nxt;
      addr_reg    <= addr_nxt;
      data_reg    <= data_nxt;
      timer       <= timer_nxt;
      in_ready    <= ready_nxt;
      config_addr <= bus_addr_nxt;
      config_data <= bus_data_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      write_count <= count_nxt;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      checksum    <= checksum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: three instances (hold/gap = 1/1, 3/0, 4/1) checked every cycle
// against a timeline model of the stream, plus directed literal checks.

module tb_config_loader;

  localparam logic [31:0] IDLE = 32'h0000_0000;
  localparam logic [31:0] ENDA = 32'hFFFF_FFFF;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam logic [31:0] BAD_ERR = 32'd1;
`else
  localparam logic [31:0] BAD_ERR = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start, in_valid, in_ready, busy, done, error, ovr;
  logic [31:0] in_data [3];
  logic [31:0] config_addr [3];
  logic [31:0] config_data [3];
  logic [15:0] write_count [3];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          checking = 1'b0;

  always #5 clk = ~clk;

  config_loader #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .config_addr(config_addr[0]), .config_data(config_data[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .write_count(write_count[0]));
  config_loader #(.HOLD_CYCLES(3), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .config_addr(config_addr[1]), .config_data(config_data[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .write_count(write_count[1]));
  config_loader #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .config_addr(config_addr[2]), .config_data(config_data[2]),
    .busy(busy[2]), .done(done[2]), .error(error[2]), .write_count(write_count[2]));

  function automatic int unsigned hold_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int unsigned gap_of(input int k);
    case (k)
      1: return 0;
      default: return 1;
    endcase
  endfunction

  // Model: tmr counts bus cycles left after a data accept (hold then gap); ready only at 0
  typedef struct packed {
    logic        act;
    logic        done;
    logic        err;
    logic        half;
    logic [15:0] cnt;
    logic [31:0] tmr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] csum;
  } mstate_t;

  mstate_t m [3];

  function automatic mstate_t step(input int k, input mstate_t s, input logic rst,
                                   input logic st, input logic v, input logic [31:0] w,
                                   input logic ov);
    mstate_t n;
    logic    fire;
    n = s;
    if (!rst) begin
      n = '0;
    end else begin
      fire = v && s.act && (s.tmr == 32'd0);
      if (s.tmr != 32'd0) n.tmr = s.tmr - 32'd1;
      if (!s.act) begin
        if (st) begin
          n.act = 1'b1; n.done = 1'b0; n.err = 1'b0; n.cnt = '0; n.csum = '0; n.half = 1'b0;
        end
      end else if (fire) begin
        if (!s.half) begin
          n.a = w;
          n.half = 1'b1;
        end else begin
          n.half = 1'b0;
          if (s.a == ENDA) begin
            n.act  = 1'b0;
            n.done = 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            n.err  = (w != s.csum);
`endif
          end else begin
            n.d    = w;
            n.tmr  = 32'(hold_of(k) + gap_of(k));
            n.csum = s.csum ^ s.a ^ w;
            if (s.cnt != 16'hFFFF) n.cnt = s.cnt + 16'd1;
          end
        end
      end
      if (ov) n.cnt = 16'hFFFE;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      m[k] <= step(k, m[k], reset, start[k], in_valid[k], in_data[k], ovr[k]);
  end

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h", name, k, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      mstate_t s;
      logic    wr;
      s  = m[k];
      wr = s.act && (s.tmr > 32'(gap_of(k)));
      chk("in_ready", k, 32'(in_ready[k]), 32'(s.act && (s.tmr == 32'd0)));
      chk("config_addr", k, config_addr[k], wr ? s.a : IDLE);
      chk("config_data", k, config_data[k], wr ? s.d : 32'd0);
      chk("busy", k, 32'(busy[k]), 32'(s.act));
      chk("done", k, 32'(done[k]), 32'(s.done));
      chk("error", k, 32'(error[k]), 32'(s.err));
      chk("write_count", k, 32'(write_count[k]), 32'(s.cnt));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (checking) compare_all();
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
      $fatal(1, "watchdog");
    end
  endtask

  task automatic start_pulse(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  // Offer one word and return at the negedge after the edge that accepted it
  task automatic push(input int k, input logic [31:0] w);
    int n;
    n = 0;
    in_data[k]  = w;
    in_valid[k] = 1'b1;
    while (!in_ready[k]) begin
      tick();
      n++;
      if (n > 100) begin
        tests++;
        fails++;
        $display("FAIL push_timeout[%0d]: in_ready stayed %b, required 1", k, in_ready[k]);
        break;
      end
    end
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic push_stall(input int k, input logic [31:0] w);
    in_valid[k] = 1'b0;
    tick();
    push(k, w);
  endtask

  initial begin
    reset = 1'b0;
    start = '0;
    in_valid = '0;
    ovr = '0;
    for (int k = 0; k < 3; k++) in_data[k] = '0;
    @(negedge clk);
    @(negedge clk);
    checking = 1'b1;
    tick();
    chk("rst_addr", 0, config_addr[0], IDLE);
    chk("rst_ready", 1, 32'(in_ready[1]), 32'd0);
    chk("rst_count", 2, 32'(write_count[2]), 32'd0);
    reset = 1'b1;
    tick();

    // Single write, hold 1 / gap 1
    start_pulse(0);
    push(0, 32'h0006_0003);
    push(0, 32'h0000_0005);
    chk("t1_bus_addr", 0, config_addr[0], 32'h0006_0003);
    chk("t1_bus_data", 0, config_data[0], 32'h0000_0005);
    tick();
    chk("t1_gap_addr", 0, config_addr[0], IDLE);
    push(0, ENDA);
    push(0, 32'h0);
    chk("t1_done", 0, 32'(done[0]), 32'd1);
    chk("t1_count", 0, 32'(write_count[0]), 32'd1);

    // Back-to-back pairs, hold 3 / gap 0
    start_pulse(1);
    push(1, 32'h0002_0001);
    push(1, 32'h1111_1111);
    chk("t2_ready_hold", 1, 32'(in_ready[1]), 32'd0);
    push(1, 32'h0002_0002);
    push(1, 32'h2222_2222);
    push(1, ENDA);
    push(1, 32'h0);
    chk("t2_count", 1, 32'(write_count[1]), 32'd2);

    // Stalled source, including a write to the idle address
    start_pulse(0);
    push_stall(0, 32'h0001_0004);
    push_stall(0, 32'hDEAD_BEEF);
    push_stall(0, 32'h0000_0000);
    push_stall(0, 32'h1234_5678);
    push_stall(0, 32'h0003_0009);
    push_stall(0, 32'hCAFE_F00D);
    push_stall(0, ENDA);
    push_stall(0, 32'h0);
    chk("t3_count", 0, 32'(write_count[0]), 32'd3);

    // Reset on the second hold cycle, start held during reset, then clean reload
    start_pulse(2);
    push(2, 32'h0005_0005);
    push(2, 32'h5555_AAAA);
    tick();
    chk("t4_holding", 2, config_addr[2], 32'h0005_0005);
    reset = 1'b0;
    start[2] = 1'b1;
    tick();
    chk("t4_rst_addr", 2, config_addr[2], IDLE);
    chk("t4_rst_busy", 2, 32'(busy[2]), 32'd0);
    chk("t4_rst_count", 2, 32'(write_count[2]), 32'd0);
    reset = 1'b1;
    start[2] = 1'b0;
    tick();
    chk("t4_no_start", 2, 32'(busy[2]), 32'd0);
    start_pulse(2);
    push(2, 32'h0005_0006);
    push(2, 32'h6666_0000);
    push(2, ENDA);
    push(2, 32'h0);
    chk("t4_reload_count", 2, 32'(write_count[2]), 32'd1);
    chk("t4_reload_done", 2, 32'(done[2]), 32'd1);

    // Checksum: matching and mismatching terminator data
    start_pulse(0);
    push(0, 32'h0007_0001);
    push(0, 32'hAAAA_5555);
    push(0, ENDA);
    push(0, 32'hAAAD_5554);
    chk("t5_good_err", 0, 32'(error[0]), 32'd0);
    start_pulse(0);
    push(0, 32'h0007_0001);
    push(0, 32'hAAAA_5555);
    push(0, ENDA);
    push(0, 32'h0);
    chk("t5_bad_err", 0, 32'(error[0]), BAD_ERR);
    chk("t5_bad_done", 0, 32'(done[0]), 32'd1);

    // Saturation and start ignored mid-write
    start_pulse(1);
    #2;
    force dut1.write_count = 16'hFFFE;
    ovr[1] = 1'b1;
    tick();
    #2;
    release dut1.write_count;
    ovr[1] = 1'b0;
    tick();
    chk("t6_preset", 1, 32'(write_count[1]), 32'h0000_FFFE);
    push(1, 32'h0004_0001);
    push(1, 32'h0000_00A1);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    chk("t6_start_ignored", 1, 32'(busy[1]), 32'd1);
    chk("t6_hold_addr", 1, config_addr[1], 32'h0004_0001);
    push(1, 32'h0004_0002);
    push(1, 32'h0000_00A2);
    push(1, 32'h0004_0003);
    push(1, 32'h0000_00A3);
    chk("t6_sat", 1, 32'(write_count[1]), 32'h0000_FFFF);
    push(1, ENDA);
    push(1, 32'h0);
    chk("t6_sat_done", 1, 32'(write_count[1]), 32'h0000_FFFF);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
